hack_cpu_ctrl: RTL and testbench

Multi-cycle Hack CPU controller that acts as the initiator of the existing 16-bit Hack ALU interface. It fetches 16-bit Hack instructions over a request/acknowledge port, holds the A, D and PC registers, and drives the ALU operand and control bits (zx, nx, zy, ny, f, no). It consumes the ALU's o/zr/ng results for register writeback and jump decisions, and performs data-memory reads and writes over a second request/acknowledge port.

---
 rtl/hack_pkg.sv | 32 +++
 rtl/hack_pc.sv | 28 ++
 rtl/hack_cpu_ctrl.sv | 125 ++++++++++++
 tb/tb_hack_cpu_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared Hack CPU definitions: datapath widths, instruction field positions,
// controller state encoding and the jump-condition helper.
package hack_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 15;

  localparam int A_FLAG  = 15;
  localparam int ABIT    = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A  = 5;
  localparam int DEST_D  = 4;
  localparam int DEST_M  = 3;
  localparam int JMP_HI  = 2;
  localparam int JMP_LO  = 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MREAD  = 3'd3,
    S_EXEC   = 3'd4,
    S_MWRITE = 3'd5
  } state_t;

  // jmp bits select which of negative / zero / positive results take the branch
  function automatic logic jumpTaken(input logic [2:0] jmp, input logic zr, input logic ng);
    return (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/hack_pc.sv
// 15-bit Hack program counter: jump load has priority over increment,
// and the increment wraps 0x7FFF -> 0x0000.
module hack_pc
  import hack_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_loadAddr,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_loadAddr;
    end else if (i_inc) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU controller: fetches instructions, sequences optional
// M read / M write bus cycles and drives the external Hack ALU from A, D and M.
module hack_cpu_ctrl
  import hack_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic              instr_req,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_ack,
  input  logic [DATA_W-1:0] instr_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic              alu_zx,
  output logic              alu_nx,
  output logic              alu_zy,
  output logic              alu_ny,
  output logic              alu_f,
  output logic              alu_no,
  input  logic [DATA_W-1:0] alu_o,
  input  logic              alu_zr,
  input  logic              alu_ng,
  output logic [ADDR_W-1:0] pc
);

  state_t            r_state;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_d;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_m;
  logic [DATA_W-1:0] r_r;
  logic [ADDR_W-1:0] r_wa;

  logic [ADDR_W-1:0] w_pc;
  logic              w_isCInstr;
  logic              w_taken;
  logic              w_pcLoad;
  logic              w_pcInc;
  logic [1:0]        w_unused;

  assign w_isCInstr = r_ir[A_FLAG];
  assign w_taken    = jumpTaken(r_ir[JMP_HI:JMP_LO], alu_zr, alu_ng);
  assign w_pcLoad   = (r_state == S_EXEC) && w_taken;
  assign w_pcInc    = ((r_state == S_DECODE) && !w_isCInstr) ||
                      ((r_state == S_EXEC) && !w_taken);
  assign w_unused   = r_ir[14:13];

  hack_pc u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_pcLoad),
    .i_inc      (w_pcInc),
    .i_loadAddr (r_a[ADDR_W-1:0]),
    .o_pc       (w_pc)
  );

  // WA captures the pre-EXEC A so an AM= destination still writes to the old address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_d     <= '0;
      r_ir    <= '0;
      r_m     <= '0;
      r_r     <= '0;
      r_wa    <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (instr_ack) begin
            r_ir    <= instr_data;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!w_isCInstr) begin
            r_a     <= {1'b0, r_ir[ADDR_W-1:0]};
            r_state <= S_FETCH;
          end else begin
            r_state <= r_ir[ABIT] ? S_MREAD : S_EXEC;
          end
        end
        S_MREAD: begin
          if (mem_ack) begin
            r_m     <= mem_rdata;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_r  <= alu_o;
          r_wa <= r_a[ADDR_W-1:0];
          if (r_ir[DEST_A]) r_a <= alu_o;
          if (r_ir[DEST_D]) r_d <= alu_o;
          r_state <= r_ir[DEST_M] ? S_MWRITE : S_FETCH;
        end
        S_MWRITE: begin
          if (mem_ack) r_state <= S_FETCH;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_req  = (r_state == S_FETCH);
  assign instr_addr = w_pc;
  assign pc         = w_pc;

  assign mem_req   = (r_state == S_MREAD) || (r_state == S_MWRITE);
  assign mem_we    = (r_state == S_MWRITE);
  assign mem_addr  = (r_state == S_MWRITE) ? r_wa :
                     (r_state == S_MREAD)  ? r_a[ADDR_W-1:0] : '0;
  assign mem_wdata = r_r;

  assign alu_x = r_d;
  assign alu_y = r_ir[ABIT] ? r_m : r_a;
  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = r_ir[COMP_HI:COMP_LO];

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed bench for hack_cpu_ctrl: behavioural ROM/RAM responders with
// programmable wait states plus a reference Hack ALU feeding the controller.
module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_req, instr_ack;
  logic [14:0] instr_addr;
  logic [15:0] instr_data;
  logic        mem_req, mem_we, mem_ack;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [15:0] alu_x, alu_y, alu_o;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
  logic [14:0] pc;
  logic [5:0]  aluCtrl;

  logic [15:0] rom  [0:32767];
  logic [15:0] dmem [0:32767];
  int          instrWait, memWait, iCnt, mCnt;
  logic        spurious;
  int          writeCount;
  logic [14:0] lastWAddr;
  logic [15:0] lastWData;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  hack_cpu_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_req  (instr_req),
    .instr_addr (instr_addr),
    .instr_ack  (instr_ack),
    .instr_data (instr_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_zx     (alu_zx),
    .alu_nx     (alu_nx),
    .alu_zy     (alu_zy),
    .alu_ny     (alu_ny),
    .alu_f      (alu_f),
    .alu_no     (alu_no),
    .alu_o      (alu_o),
    .alu_zr     (alu_zr),
    .alu_ng     (alu_ng),
    .pc         (pc)
  );

  // Reference Hack ALU, controls ordered {zx,nx,zy,ny,f,no}
  function automatic logic [15:0] hackAlu(input logic [15:0] x, input logic [15:0] y,
                                          input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0000 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0000 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? (xx + yy) : (xx & yy);
    if (c[0]) o = ~o;
    return o;
  endfunction

  assign aluCtrl = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
  assign alu_o   = hackAlu(alu_x, alu_y, aluCtrl);
  assign alu_zr  = (alu_o == 16'h0000);
  assign alu_ng  = alu_o[15];

  // Responders: ack after instrWait/memWait idle request cycles; optional spurious acks
  always @(negedge clk) begin
    if (instr_req) begin
      instr_ack  = (iCnt >= instrWait);
      instr_data = rom[instr_addr];
      iCnt++;
    end else begin
      instr_ack  = spurious;
      instr_data = 16'hFFFF;
      iCnt       = 0;
    end
    if (mem_req) begin
      mem_ack   = (mCnt >= memWait);
      mem_rdata = dmem[mem_addr];
      mCnt++;
    end else begin
      mem_ack   = spurious;
      mem_rdata = 16'hFFFF;
      mCnt      = 0;
    end
  end

  always @(posedge clk) begin
    if (rst_n && mem_req && mem_we && mem_ack) begin
      dmem[mem_addr] = mem_wdata;
      lastWAddr      = mem_addr;
      lastWData      = mem_wdata;
      writeCount++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clearMem();
    for (int i = 0; i < 32768; i++) begin
      rom[i]  = 16'h0000;
      dmem[i] = 16'h0000;
    end
    instrWait  = 0;
    memWait    = 0;
    spurious   = 1'b0;
    writeCount = 0;
  endtask

  // Leaves the bench 1 time unit after the releasing negedge, DUT in IDLE
  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    writeCount = 0;
    #1;
  endtask

  task automatic test_reset();
    clearMem();
    rom[0]  = 16'h0064;
    rom[1]  = 16'hE308;
    memWait = 100;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({instr_req, mem_req, mem_we} !== 3'b000) begin errors++; $display("[TB] FAIL rst_reqs: got %b expected 000", {instr_req, mem_req, mem_we}); end
    checks++; if (pc !== 15'h0000 || instr_addr !== 15'h0000) begin errors++; $display("[TB] FAIL rst_pc: got pc=%h addr=%h expected 0", pc, instr_addr); end
    checks++; if (mem_addr !== 15'h0000 || mem_wdata !== 16'h0000) begin errors++; $display("[TB] FAIL rst_mem: got addr=%h wdata=%h expected 0", mem_addr, mem_wdata); end
    checks++; if (aluCtrl !== 6'b000000 || alu_x !== 16'h0 || alu_y !== 16'h0) begin errors++; $display("[TB] FAIL rst_alu: got ctrl=%b x=%h y=%h expected 0", aluCtrl, alu_x, alu_y); end
    rst_n = 1'b1;
    checks++; if (instr_req !== 1'b0) begin errors++; $display("[TB] FAIL idle_req: got %b expected 0", instr_req); end
    step();
    checks++; if (instr_req !== 1'b1 || instr_addr !== 15'h0000) begin errors++; $display("[TB] FAIL first_fetch: got req=%b addr=%h expected 1/0000", instr_req, instr_addr); end
    repeat (5) step();
    checks++; if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 15'd100 || pc !== 15'd2) begin errors++; $display("[TB] FAIL mwrite_state: got req/we=%b addr=%0d pc=%0d expected 11/100/2", {mem_req, mem_we}, mem_addr, pc); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({instr_req, mem_req, mem_we} !== 3'b000 || pc !== 15'h0000) begin errors++; $display("[TB] FAIL async_rst: got reqs=%b pc=%h expected 000/0", {instr_req, mem_req, mem_we}, pc); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (writeCount !== 0) begin errors++; $display("[TB] FAIL rst_no_write: got %0d expected 0", writeCount); end
    step();
    checks++; if (instr_req !== 1'b1 || instr_addr !== 15'h0000) begin errors++; $display("[TB] FAIL restart_fetch: got req=%b addr=%h expected 1/0000", instr_req, instr_addr); end
  endtask

  task automatic test_d_eq_a();
    clearMem();
    rom[0]   = 16'h0005;
    rom[1]   = 16'hEC10;
    spurious = 1'b1;
    doReset();
    step();
    checks++; if (instr_req !== 1'b1 || instr_addr !== 15'd0) begin errors++; $display("[TB] FAIL dA_fetch0: got req=%b addr=%h expected 1/0", instr_req, instr_addr); end
    step();
    checks++; if (instr_req !== 1'b0) begin errors++; $display("[TB] FAIL dA_decode_req: got %b expected 0", instr_req); end
    step();
    checks++; if (alu_y !== 16'd5 || pc !== 15'd1 || instr_addr !== 15'd1) begin errors++; $display("[TB] FAIL dA_a5: got A=%h pc=%h expected 5/1", alu_y, pc); end
    repeat (2) step();
    checks++; if (aluCtrl !== 6'b110000 || alu_y !== 16'd5 || alu_x !== 16'd0) begin errors++; $display("[TB] FAIL dA_exec: got ctrl=%b y=%h x=%h expected 110000/5/0", aluCtrl, alu_y, alu_x); end
    checks++; if ({instr_req, mem_req} !== 2'b00) begin errors++; $display("[TB] FAIL dA_exec_reqs: got %b expected 00", {instr_req, mem_req}); end
    step();
    checks++; if (alu_x !== 16'd5 || pc !== 15'd2) begin errors++; $display("[TB] FAIL dA_result: got D=%h pc=%h expected 5/2", alu_x, pc); end
    checks++; if (writeCount !== 0) begin errors++; $display("[TB] FAIL dA_spurious_write: got %0d expected 0", writeCount); end
    spurious = 1'b0;
  endtask

  task automatic test_m_plus_d();
    bit found;
    clearMem();
    rom[0]    = 16'h0005;
    rom[1]    = 16'hEC10;
    rom[2]    = 16'h0064;
    rom[3]    = 16'hF088;
    dmem[100] = 16'd7;
    doReset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (mem_req) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL mpd_timeout: got no mem_req expected one within 40 cycles"); end
    checks++; if (mem_we !== 1'b0 || mem_addr !== 15'd100) begin errors++; $display("[TB] FAIL mpd_mread: got we=%b addr=%0d expected 0/100", mem_we, mem_addr); end
    step();
    checks++; if (mem_req !== 1'b0 || alu_y !== 16'd7 || alu_x !== 16'd5 || aluCtrl !== 6'b000010) begin errors++; $display("[TB] FAIL mpd_exec: got req=%b y=%h x=%h ctrl=%b expected 0/7/5/000010", mem_req, alu_y, alu_x, aluCtrl); end
    step();
    checks++; if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 15'd100 || mem_wdata !== 16'd12) begin errors++; $display("[TB] FAIL mpd_mwrite: got req/we=%b addr=%0d wdata=%0d expected 11/100/12", {mem_req, mem_we}, mem_addr, mem_wdata); end
    repeat (10) step();
    checks++; if (writeCount !== 1 || dmem[100] !== 16'd12) begin errors++; $display("[TB] FAIL mpd_writes: got count=%0d mem=%0d expected 1/12", writeCount, dmem[100]); end
  endtask

  task automatic test_jeq();
    clearMem();
    rom[0] = 16'h0028;
    rom[1] = 16'hE302;
    doReset();
    repeat (5) step();
    checks++; if (alu_x !== 16'd0 || alu_zr !== 1'b1) begin errors++; $display("[TB] FAIL jeq_exec0: got D=%h zr=%b expected 0/1", alu_x, alu_zr); end
    step();
    checks++; if (pc !== 15'd40 || instr_addr !== 15'd40) begin errors++; $display("[TB] FAIL jeq_taken: got pc=%0d expected 40", pc); end
    clearMem();
    rom[0] = 16'hEFD0;
    rom[1] = 16'h0028;
    rom[2] = 16'hE302;
    doReset();
    repeat (8) step();
    checks++; if (alu_x !== 16'd1 || alu_y !== 16'd40) begin errors++; $display("[TB] FAIL jeq_exec1: got D=%h A=%h expected 1/28", alu_x, alu_y); end
    step();
    checks++; if (pc !== 15'd3) begin errors++; $display("[TB] FAIL jeq_not_taken: got pc=%0d expected 3", pc); end
  endtask

  task automatic test_wait_states();
    logic        pIWait, pMWait;
    logic [14:0] pIAddr, pMAddr;
    logic [15:0] pX, pY, pWdata;
    logic [5:0]  pCtrl;
    logic        pWe;
    int          writeCyc;
    clearMem();
    rom[0]    = 16'h0007;
    rom[1]    = 16'hEC10;
    rom[2]    = 16'h0064;
    rom[3]    = 16'hE308;
    instrWait = 3;
    memWait   = 3;
    doReset();
    pIWait   = 1'b0;
    pMWait   = 1'b0;
    writeCyc = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      step();
      if (pIWait) begin
        checks++; if (instr_req !== 1'b1 || instr_addr !== pIAddr) begin errors++; $display("[TB] FAIL ws_ireq_hold: cycle %0d got req=%b addr=%h expected 1/%h", cyc, instr_req, instr_addr, pIAddr); end
        checks++; if (aluCtrl !== pCtrl || alu_x !== pX || alu_y !== pY) begin errors++; $display("[TB] FAIL ws_regs_hold: cycle %0d got ctrl=%b x=%h y=%h expected %b/%h/%h", cyc, aluCtrl, alu_x, alu_y, pCtrl, pX, pY); end
      end
      if (pMWait) begin
        checks++; if (mem_req !== 1'b1 || mem_we !== pWe || mem_addr !== pMAddr || mem_wdata !== pWdata) begin errors++; $display("[TB] FAIL ws_mreq_hold: cycle %0d got req=%b we=%b addr=%h wdata=%h expected 1/%b/%h/%h", cyc, mem_req, mem_we, mem_addr, mem_wdata, pWe, pMAddr, pWdata); end
        checks++; if (alu_x !== pX) begin errors++; $display("[TB] FAIL ws_d_hold: cycle %0d got %h expected %h", cyc, alu_x, pX); end
      end
      if (mem_req && mem_we && mem_ack && writeCyc < 0) writeCyc = cyc;
      pIWait = instr_req && !instr_ack;
      pMWait = mem_req && !mem_ack;
      pIAddr = instr_addr;
      pMAddr = mem_addr;
      pWdata = mem_wdata;
      pWe    = mem_we;
      pCtrl  = aluCtrl;
      pX     = alu_x;
      pY     = alu_y;
    end
    checks++; if (writeCyc !== 26) begin errors++; $display("[TB] FAIL ws_timing: got write ack in cycle %0d expected 26", writeCyc); end
    checks++; if (writeCount !== 1 || lastWAddr !== 15'd100 || lastWData !== 16'd7) begin errors++; $display("[TB] FAIL ws_write: got count=%0d addr=%0d data=%h expected 1/100/0007", writeCount, lastWAddr, lastWData); end
  endtask

  task automatic test_am_m_plus_1();
    bit found;
    clearMem();
    rom[0]    = 16'h0064;
    rom[1]    = 16'hFDE8;
    rom[2]    = 16'hEC10;
    dmem[100] = 16'h7FFF;
    doReset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (mem_req && mem_we) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL am_timeout: got no write expected one within 40 cycles"); end
    checks++; if (mem_addr !== 15'd100 || mem_wdata !== 16'h8000) begin errors++; $display("[TB] FAIL am_write: got addr=%0d wdata=%h expected 100/8000", mem_addr, mem_wdata); end
    repeat (3) step();
    checks++; if (alu_y !== 16'h8000) begin errors++; $display("[TB] FAIL am_new_a: got A=%h expected 8000", alu_y); end
    step();
    checks++; if (alu_x !== 16'h8000 || writeCount !== 1) begin errors++; $display("[TB] FAIL am_d_copy: got D=%h writes=%0d expected 8000/1", alu_x, writeCount); end
  endtask

  task automatic test_pc_wrap();
    clearMem();
    rom[0]     = 16'h7FFF;
    rom[1]     = 16'hEA87;
    rom[32767] = 16'h0003;
    doReset();
    repeat (6) step();
    checks++; if (pc !== 15'h7FFF || instr_req !== 1'b1 || instr_addr !== 15'h7FFF) begin errors++; $display("[TB] FAIL wrap_jump: got pc=%h req=%b expected 7fff/1", pc, instr_req); end
    repeat (2) step();
    checks++; if (pc !== 15'h0000 || alu_y !== 16'd3) begin errors++; $display("[TB] FAIL wrap_pc: got pc=%h A=%h expected 0000/0003", pc, alu_y); end
  endtask

  initial begin
    iCnt      = 0;
    mCnt      = 0;
    instr_ack = 1'b0;
    mem_ack   = 1'b0;
    instr_data = 16'h0000;
    mem_rdata  = 16'h0000;
    $display("[TB] hack_cpu_ctrl directed tests starting");
    test_reset();
    test_d_eq_a();
    test_m_plus_d();
    test_jeq();
    test_wait_states();
    test_am_m_plus_1();
    test_pc_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
